// File: rtl/scanline_sequencer_pkg.sv
// Shared types and sizing helpers for the scanline sequencer.
// States, counter widths and the default wait limit.
package scanline_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_WAIT_CFG,
    S_WAIT_RDY,
    S_PRESENT,
    S_ACK,
    S_LINE_END,
    S_ABORT
  } seq_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scanline_sequencer_timeout.sv
// Wait-state watchdog for the scanline sequencer.
// Counts enabled cycles; expired on the LIMIT-th enabled cycle.
module seq_timeout_counter
  import scanline_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W = cnt_width(LIMIT);

  logic [W-1:0] r_cnt;
  logic         w_at_limit;

  assign w_at_limit = (r_cnt == W'(LIMIT - 1));
  assign o_expired  = i_enable && w_at_limit;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/scanline_sequencer.sv
// Drives the delay array through whole scanlines and paces it
// against a valid/ready transmit consumer.
module scanline_sequencer
  import scanline_sequencer_pkg::*;
#(
  parameter int unsigned DW_INPUT       = 8,
  parameter int unsigned DW_ANGLE       = 8,
  parameter int unsigned NUM_POINTS     = 256,
  parameter int unsigned DW_LINES       = 8,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int unsigned PW = cnt_width(NUM_POINTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [DW_INPUT-1:0] i_r_0_cfg,
  input  logic [DW_ANGLE-1:0] i_angle_start,
  input  logic [DW_ANGLE-1:0] i_angle_step,
  input  logic [DW_LINES-1:0] i_num_lines,
  input  logic                i_arr_ready,
  input  logic                i_arr_done_cfg,
  input  logic                i_tx_ready,
  output logic [DW_INPUT-1:0] o_r_0,
  output logic [DW_ANGLE-1:0] o_angle,
  output logic                o_configure,
  output logic                o_ack,
  output logic                o_final_scanpoint,
  output logic                o_transmit_done,
  output logic                o_tx_valid,
  output logic [PW-1:0]       o_point_idx,
  output logic [DW_LINES-1:0] o_line_idx,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_timeout_err
);

  seq_state_e          r_state, w_next;
  logic [DW_INPUT-1:0] r_r0;
  logic [DW_ANGLE-1:0] r_angle, r_step;
  logic [DW_LINES-1:0] r_num_lines, r_line;
  logic [PW-1:0]       r_point;
  logic                r_timeout_err, r_frame_done;

  logic w_last_pt, w_last_line, w_waiting;
  logic w_tmo_clear, w_expired, w_timeout;

  assign w_last_pt   = (r_point == PW'(NUM_POINTS - 1));
  assign w_last_line = (r_line == (r_num_lines - DW_LINES'(1)));
  assign w_waiting   = (r_state == S_WAIT_CFG) || (r_state == S_WAIT_RDY);
  // Restart the watchdog every time a wait state is (re)entered.
  assign w_tmo_clear = !w_waiting || (w_next != r_state);

  seq_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmo_clear),
    .i_enable (w_waiting),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (i_start && (i_num_lines != '0)) w_next = S_CONFIG;
      S_CONFIG:
        w_next = S_WAIT_CFG;
      S_WAIT_CFG:
        if (i_arr_done_cfg) begin
          w_next = S_WAIT_RDY;
        end else if (w_expired) begin
          w_next    = S_ABORT;
          w_timeout = 1'b1;
        end
      S_WAIT_RDY:
        if (i_arr_ready) begin
          w_next = S_PRESENT;
        end else if (w_expired) begin
          w_next    = S_ABORT;
          w_timeout = 1'b1;
        end
      S_PRESENT:
        if (i_tx_ready) w_next = S_ACK;
      S_ACK:
        w_next = w_last_pt ? S_LINE_END : S_WAIT_RDY;
      S_LINE_END:
        w_next = w_last_line ? S_IDLE : S_CONFIG;
      S_ABORT:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
      w_next    = S_ABORT;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_r0          <= '0;
      r_angle       <= '0;
      r_step        <= '0;
      r_num_lines   <= '0;
      r_line        <= '0;
      r_point       <= '0;
      r_timeout_err <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= 1'b0;
      if ((r_state == S_IDLE) && i_start) begin
        r_timeout_err <= 1'b0;
        if (i_num_lines == '0) begin
          r_frame_done <= 1'b1;
        end else begin
          r_r0        <= i_r_0_cfg;
          r_angle     <= i_angle_start;
          r_step      <= i_angle_step;
          r_num_lines <= i_num_lines;
          r_line      <= '0;
          r_point     <= '0;
        end
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if ((r_state == S_ACK) && (w_next == S_WAIT_RDY)) begin
        r_point <= r_point + PW'(1);
      end
      if ((r_state == S_LINE_END) && (w_next != S_ABORT)) begin
        r_point <= '0;
        if (w_last_line) begin
          r_frame_done <= 1'b1;
        end else begin
          r_line  <= r_line + DW_LINES'(1);
          r_angle <= r_angle + r_step;
        end
      end
    end
  end

  assign o_r_0             = r_r0;
  assign o_angle           = r_angle;
  assign o_configure       = (r_state == S_CONFIG);
  assign o_ack             = (r_state == S_ACK);
  assign o_final_scanpoint = ((r_state == S_ACK) && w_last_pt) ||
                             (r_state == S_ABORT);
  assign o_transmit_done   = (r_state == S_LINE_END);
  assign o_tx_valid        = (r_state == S_PRESENT);
  assign o_point_idx       = r_point;
  assign o_line_idx        = r_line;
  assign o_busy            = (r_state != S_IDLE);
  assign o_frame_done      = r_frame_done;
  assign o_timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_scanline_sequencer.sv
// Bench for scanline_sequencer: array/consumer responder, event
// monitor and a per-frame expectation model.
module tb_scanline_sequencer;

  localparam int NP  = 4;
  localparam int TMO = 16;

  logic       clk, rst;
  logic       i_start, i_abort;
  logic [7:0] i_r_0_cfg, i_angle_start, i_angle_step, i_num_lines;
  logic       i_arr_ready, i_arr_done_cfg, i_tx_ready;
  logic [7:0] o_r_0, o_angle, o_line_idx;
  logic [1:0] o_point_idx;
  logic       o_configure, o_ack, o_final_scanpoint, o_transmit_done;
  logic       o_tx_valid, o_busy, o_frame_done, o_timeout_err;

  scanline_sequencer #(
    .DW_INPUT(8), .DW_ANGLE(8), .NUM_POINTS(NP),
    .DW_LINES(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_abort(i_abort),
    .i_r_0_cfg(i_r_0_cfg), .i_angle_start(i_angle_start),
    .i_angle_step(i_angle_step), .i_num_lines(i_num_lines),
    .i_arr_ready(i_arr_ready), .i_arr_done_cfg(i_arr_done_cfg),
    .i_tx_ready(i_tx_ready),
    .o_r_0(o_r_0), .o_angle(o_angle), .o_configure(o_configure),
    .o_ack(o_ack), .o_final_scanpoint(o_final_scanpoint),
    .o_transmit_done(o_transmit_done), .o_tx_valid(o_tx_valid),
    .o_point_idx(o_point_idx), .o_line_idx(o_line_idx),
    .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_timeout_err(o_timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // environment knobs
  int cfg_en = 1, cfg_dly = 1, rdy_dly = 2;
  int tx_rand = 0, hold_on = 0, hold_pt = 0;

  // monitor state
  int cyc = 0, t_cfg = 0, t_fin = 0, t_ack = -1000;
  int n_cfg, n_ack, n_fin, n_td, n_fd, n_viol;
  int since_cfg = 0, since_evt = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_hs = 1'b0;
  logic [7:0] q_ang[$], q_r0[$], q_line[$];
  logic [1:0] q_pt[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_cfg = 0; n_ack = 0; n_fin = 0; n_td = 0; n_fd = 0; n_viol = 0;
    q_ang.delete(); q_r0.delete(); q_line.delete(); q_pt.delete();
  endtask

  // Monitor first, then respond for the coming edge.
  initial begin
    clr_mon();
    forever begin
      @(negedge clk);
      cyc++;
      if (o_configure) begin
        n_cfg++;
        q_ang.push_back(o_angle);
        q_r0.push_back(o_r_0);
        q_line.push_back(o_line_idx);
        t_cfg = cyc;
        since_cfg = 0;
        since_evt = 0;
      end
      if (o_ack) begin
        n_ack++;
        q_pt.push_back(o_point_idx);
        if (!p_hs) n_viol++;
        t_ack = cyc;
        since_evt = 0;
      end
      if (o_final_scanpoint) begin
        n_fin++;
        t_fin = cyc;
        if (o_ack && (o_point_idx != 2'(NP - 1))) n_viol++;
      end
      if (o_transmit_done) n_td++;
      if (o_frame_done) n_fd++;
      if (o_tx_valid && !p_valid && (cyc - t_ack) < 2) n_viol++;
      if (p_valid && !p_ready && !o_tx_valid && !o_final_scanpoint)
        n_viol++;
      i_arr_done_cfg = (cfg_en != 0) && (since_cfg >= cfg_dly);
      i_arr_ready    = (since_evt >= rdy_dly);
      if (hold_on != 0 && o_point_idx == 2'(hold_pt))
        i_tx_ready = 1'b0;
      else if (tx_rand != 0)
        i_tx_ready = ($urandom_range(0, 3) != 0);
      else
        i_tx_ready = 1'b1;
      since_cfg++;
      since_evt++;
      p_valid = o_tx_valid;
      p_ready = i_tx_ready;
      p_hs    = o_tx_valid && i_tx_ready;
    end
  end

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic run_frame(input int r0, input int a0,
                           input int st, input int nl);
    bit done = 0;
    clr_mon();
    i_r_0_cfg = 8'(r0); i_angle_start = 8'(a0);
    i_angle_step = 8'(st); i_num_lines = 8'(nl);
    pulse_start();
    i_r_0_cfg = 8'($urandom); i_angle_start = 8'($urandom);
    i_angle_step = 8'($urandom); i_num_lines = 8'($urandom);
    for (int k = 0; k < 3000 && !done; k++) begin
      if (n_fd != 0) done = 1;
      else if (k == 3 && o_busy) begin
        i_start = 1'b1;
        step();
        i_start = 1'b0;
      end else step();
    end
    chk("frame_end_seen", 32'(done), 1);
    chk("configure_cnt", n_cfg, nl);
    chk("ack_cnt", n_ack, nl * NP);
    chk("final_cnt", n_fin, nl);
    chk("tx_done_cnt", n_td, nl);
    chk("frame_done_cnt", n_fd, 1);
    chk("protocol_viol", n_viol, 0);
    chk("busy_after", o_busy, 0);
    chk("tmo_err_after", o_timeout_err, 0);
    if (q_ang.size() == nl) begin
      for (int i = 0; i < nl; i++) begin
        chk("line_angle", q_ang[i], (a0 + i * st) % 256);
        chk("line_r0", q_r0[i], r0);
        chk("line_idx", q_line[i], i);
      end
    end
    if (q_pt.size() == nl * NP) begin
      for (int i = 0; i < nl * NP; i++)
        chk("ack_point", q_pt[i], i % NP);
    end
  endtask

  initial begin
    int ack0;
    i_start = 0; i_abort = 0; i_r_0_cfg = 0; i_angle_start = 0;
    i_angle_step = 0; i_num_lines = 0;
    i_arr_ready = 0; i_arr_done_cfg = 0; i_tx_ready = 0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_cfg", o_configure, 0);
    chk("rst_final", o_final_scanpoint, 0);
    chk("rst_r0", o_r_0, 0);
    chk("rst_angle", o_angle, 0);
    chk("rst_point", o_point_idx, 0);
    chk("rst_line", o_line_idx, 0);
    chk("rst_fd", o_frame_done, 0);
    chk("rst_tmo", o_timeout_err, 0);
    rst = 1'b0;
    step();

    run_frame(33, 10, 5, 2);
    run_frame(7, 250, 10, 2);

    tx_rand = 1;
    for (int it = 0; it < 6; it++) begin
      cfg_dly = $urandom_range(0, 5);
      rdy_dly = $urandom_range(0, 4);
      run_frame($urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(1, 4));
    end
    tx_rand = 0; cfg_dly = 1; rdy_dly = 2;

    // consumer stalls point 0 for 20 cycles
    clr_mon();
    hold_on = 1; hold_pt = 0;
    i_num_lines = 1;
    pulse_start();
    for (int k = 0; k < 50 && !o_tx_valid; k++) step();
    chk("bp_valid_up", o_tx_valid, 1);
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 19) begin
        chk("bp_valid_held", o_tx_valid, 1);
        chk("bp_no_ack", n_ack, 0);
      end
    end
    ack0 = n_ack;
    hold_on = 0;
    repeat (3) step();
    chk("bp_one_ack", n_ack, ack0 + 1);
    for (int k = 0; k < 200 && o_busy; k++) step();
    chk("bp_frame_acks", n_ack, NP);
    chk("bp_viol", n_viol, 0);

    // abort while presenting point 2
    clr_mon();
    hold_on = 1; hold_pt = 2;
    i_num_lines = 3;
    pulse_start();
    for (int k = 0; k < 200 && !(o_tx_valid && o_point_idx == 2); k++)
      step();
    chk("ab_at_pt2", o_tx_valid && (o_point_idx == 2), 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("ab_final", o_final_scanpoint, 1);
    chk("ab_valid", o_tx_valid, 0);
    chk("ab_ack", o_ack, 0);
    step();
    chk("ab_busy", o_busy, 0);
    chk("ab_fin_cnt", n_fin, 1);
    chk("ab_ack_cnt", n_ack, 2);
    repeat (2) step();
    chk("ab_no_fd", n_fd, 0);
    hold_on = 0;

    // array never finishes configuring
    clr_mon();
    cfg_en = 0;
    i_num_lines = 2;
    pulse_start();
    for (int k = 0; k < 200 && o_busy; k++) step();
    chk("tmo_busy", o_busy, 0);
    chk("tmo_latency", t_fin - t_cfg, TMO + 1);
    chk("tmo_err", o_timeout_err, 1);
    chk("tmo_fin", n_fin, 1);
    chk("tmo_acks", n_ack, 0);
    step();
    chk("tmo_sticky", o_timeout_err, 1);
    chk("tmo_no_fd", n_fd, 0);
    cfg_en = 1;

    // zero-line frame
    clr_mon();
    i_num_lines = 0;
    pulse_start();
    chk("zero_fd", o_frame_done, 1);
    chk("zero_busy", o_busy, 0);
    chk("zero_tmo_clr", o_timeout_err, 0);
    step();
    chk("zero_fd_pulse", o_frame_done, 0);
    chk("zero_cfg", n_cfg, 0);

    // reset mid-line
    i_r_0_cfg = 8'd99; i_angle_start = 8'd40; i_num_lines = 2;
    pulse_start();
    for (int k = 0; k < 100 && !o_tx_valid; k++) step();
    rst = 1'b1;
    step();
    chk("mrst_busy", o_busy, 0);
    chk("mrst_valid", o_tx_valid, 0);
    chk("mrst_r0", o_r_0, 0);
    chk("mrst_angle", o_angle, 0);
    chk("mrst_point", o_point_idx, 0);
    chk("mrst_line", o_line_idx, 0);
    rst = 1'b0;
    step();
    run_frame(1, 0, 64, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
